// File: rtl/mcdf_arb_pkg.sv
// Shared types and helpers for the MCDF channel arbiter.
// Channel ids are 2 bits wide even though only three channels exist.
package mcdf_arb_pkg;

  localparam int NCH = 3;

  typedef logic [1:0] chid_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_e;

  // Round-robin successor over channels 0..NCH-1.
  function automatic chid_t next_rr(input chid_t c);
    return (c >= chid_t'(NCH - 1)) ? chid_t'(0) : chid_t'(c + 2'd1);
  endfunction

endpackage

// File: rtl/mcdf_rr_prio_sel.sv
// Combinational winner select: lowest priority value wins, and ties are
// broken round-robin starting just after the last granted channel.
module mcdf_rr_prio_sel
  import mcdf_arb_pkg::*;
(
  input  logic [NCH-1:0]   eligible,
  input  logic [2*NCH-1:0] prios,
  input  chid_t            last_grant,
  output chid_t            winner,
  output logic             win_vld
);

  logic [1:0] best;
  chid_t      ch;

  always_comb begin
    best = 2'b11;
    for (int i = 0; i < NCH; i++) begin
      if (eligible[i] && (prios[2*i +: 2] < best)) begin
        best = prios[2*i +: 2];
      end
    end

    winner  = '0;
    win_vld = 1'b0;
    ch      = next_rr(last_grant);
    for (int k = 0; k < NCH; k++) begin
      if (!win_vld && eligible[ch] && (prios[2*int'(ch) +: 2] == best)) begin
        winner  = ch;
        win_vld = 1'b1;
      end
      ch = next_rr(ch);
    end
  end

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF arbiter: picks one slave channel per formatter request and streams
// exactly one packet of that channel's programmed length.
//
//   state | meaning
//   IDLE  | waiting for f2a_id_req with at least one eligible channel
//   ARB   | one cycle: winner, length and round-robin pointer registered
//   XFER  | streaming beats of the granted channel until the last one is acked
module mcdf_arbiter
  import mcdf_arb_pkg::*;
#(
  parameter int DW   = 32,
  parameter int LENW = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      chnl_en,
  input  logic [2*NCH-1:0]    slv_prios,
  input  logic [NCH-1:0]      slv_reqs,
  input  logic [NCH*LENW-1:0] slv_lens,
  input  logic [NCH*DW-1:0]   slv_datas,
  input  logic [NCH-1:0]      slv_vlds,
  output logic [NCH-1:0]      a2s_acks,
  input  logic                f2a_id_req,
  input  logic                f2a_ack,
  output logic                a2f_val,
  output chid_t               a2f_id,
  output logic [DW-1:0]       a2f_data,
  output logic [LENW-1:0]     a2f_len
);

  state_e            state;
  state_e            state_nxt;
  chid_t             last_grant;
  logic [LENW-1:0]   beat_cnt;
  logic [NCH-1:0]    eligible;
  chid_t             winner;
  logic              win_vld;
  logic [LENW-1:0]   win_len;
  logic              xfer_ack;
  logic              last_beat;

  assign eligible  = slv_reqs & chnl_en;
  assign win_len   = slv_lens[int'(winner)*LENW +: LENW];
  assign xfer_ack  = (state == XFER) && slv_vlds[a2f_id] && f2a_ack;
  assign last_beat = (beat_cnt == (a2f_len - LENW'(1)));

  mcdf_rr_prio_sel u_sel (
    .eligible   (eligible),
    .prios      (slv_prios),
    .last_grant (last_grant),
    .winner     (winner),
    .win_vld    (win_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (f2a_id_req && (eligible != '0)) state_nxt = ARB;
      ARB:  state_nxt = win_vld ? XFER : IDLE;
      XFER: if (xfer_ack && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a2f_val  = 1'b0;
    a2f_data = '0;
    a2s_acks = '0;
    if (state == XFER) begin
      a2f_val  = slv_vlds[a2f_id];
      a2f_data = slv_datas[int'(a2f_id)*DW +: DW];
      a2s_acks[a2f_id] = xfer_ack;
    end
  end

  // Grant bookkeeping; a zero programmed length still moves one beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= chid_t'(2);
      a2f_id     <= '0;
      a2f_len    <= '0;
      beat_cnt   <= '0;
    end else begin
      if ((state == ARB) && win_vld) begin
        last_grant <= winner;
        a2f_id     <= winner;
        a2f_len    <= (win_len == '0) ? LENW'(1) : win_len;
        beat_cnt   <= '0;
      end else if (xfer_ack) begin
        beat_cnt <= beat_cnt + LENW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed bench for mcdf_arbiter: a table of single-packet grants plus
// hand-written stall, ARB-abort and mid-packet reset sequences.
module tb_mcdf_arbiter;
  import mcdf_arb_pkg::*;

  localparam int DW   = 32;
  localparam int LENW = 6;

  logic                clk;
  logic                rst;
  logic [2:0]          chnl_en;
  logic [5:0]          slv_prios;
  logic [2:0]          slv_reqs;
  logic [3*LENW-1:0]   slv_lens;
  logic [3*DW-1:0]     slv_datas;
  logic [2:0]          slv_vlds;
  logic [2:0]          a2s_acks;
  logic                f2a_id_req;
  logic                f2a_ack;
  logic                a2f_val;
  chid_t               a2f_id;
  logic [DW-1:0]       a2f_data;
  logic [LENW-1:0]     a2f_len;

  mcdf_arbiter #(.DW(DW), .LENW(LENW)) dut (
    .clk        (clk),
    .rst        (rst),
    .chnl_en    (chnl_en),
    .slv_prios  (slv_prios),
    .slv_reqs   (slv_reqs),
    .slv_lens   (slv_lens),
    .slv_datas  (slv_datas),
    .slv_vlds   (slv_vlds),
    .a2s_acks   (a2s_acks),
    .f2a_id_req (f2a_id_req),
    .f2a_ack    (f2a_ack),
    .a2f_val    (a2f_val),
    .a2f_id     (a2f_id),
    .a2f_data   (a2f_data),
    .a2f_len    (a2f_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  en;
    logic [2:0]  reqs;
    logic [5:0]  prios;
    logic [17:0] lens;
    logic [1:0]  exp_id;
    int          exp_len;
  } vec_t;

  vec_t vecs [14];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   pop_cnt [3];
  logic [1:0] last_id;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int ch);
    return {8'(ch + 1), 24'(pop_cnt[ch])};
  endfunction

  task automatic refresh_data();
    for (int c = 0; c < 3; c++) slv_datas[c*DW +: DW] = exp_data(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pkt(input logic [1:0] exp_id, input int exp_len, input bit stall,
                         input string nm);
    int n;
    logic [2:0] exp_ack;
    f2a_id_req = 1'b1;
    tick();
    f2a_id_req = stall;
    #1;
    chk({nm, " arb_state"}, 64'(dut.state), 64'(ARB));
    chk({nm, " arb_val"}, 64'(a2f_val), 64'd0);
    chk({nm, " arb_acks"}, 64'(a2s_acks), 64'd0);
    tick();
    chk({nm, " id"}, 64'(a2f_id), 64'(exp_id));
    chk({nm, " len"}, 64'(a2f_len), 64'(exp_len));
    n = 0;
    for (int c = 0; c < 400 && n < exp_len; c++) begin
      if (stall) begin
        f2a_ack = (c % 3) != 1;
        slv_vlds[exp_id] = (c % 4) != 2;
        if (c == 2) begin
          chnl_en  = 3'b000;
          slv_reqs = 3'b000;
        end
      end
      #1;
      exp_ack = (slv_vlds[exp_id] && f2a_ack) ? (3'b001 << exp_id) : 3'b000;
      chk($sformatf("%s val c%0d", nm, c), 64'(a2f_val), 64'(slv_vlds[exp_id]));
      chk($sformatf("%s acks c%0d", nm, c), 64'(a2s_acks), 64'(exp_ack));
      if (exp_ack != 3'b000) begin
        chk($sformatf("%s data b%0d", nm, n), 64'(a2f_data), 64'(exp_data(int'(exp_id))));
        n++;
      end
      tick();
      if (exp_ack != 3'b000) begin
        pop_cnt[exp_id]++;
        refresh_data();
      end
    end
    f2a_ack    = 1'b1;
    slv_vlds   = 3'b111;
    f2a_id_req = 1'b0;
    #1;
    chk({nm, " beats"}, 64'(n), 64'(exp_len));
    chk({nm, " end_state"}, 64'(dut.state), 64'(IDLE));
    chk({nm, " end_val"}, 64'(a2f_val), 64'd0);
    chk({nm, " end_acks"}, 64'(a2s_acks), 64'd0);
    last_id = exp_id;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Round-robin tie from reset: 0,1,2,0,1,2
    for (int i = 0; i < 6; i++)
      vecs[i] = '{3'b111, 3'b111, 6'b01_01_01, {6'd2, 6'd2, 6'd2}, 2'(i % 3), 2};
    // Priorities ch0=2, ch1=0, ch2=1; each winner drops its request
    vecs[6]  = '{3'b111, 3'b111, 6'b01_00_10, {6'd5, 6'd2, 6'd3}, 2'd1, 2};
    vecs[7]  = '{3'b111, 3'b101, 6'b01_00_10, {6'd5, 6'd2, 6'd3}, 2'd2, 5};
    vecs[8]  = '{3'b111, 3'b001, 6'b01_00_10, {6'd5, 6'd2, 6'd3}, 2'd0, 3};
    vecs[9]  = '{3'b001, 3'b001, 6'b00_00_00, {6'd0, 6'd0, 6'd4}, 2'd0, 4};
    vecs[10] = '{3'b010, 3'b010, 6'b00_00_00, {6'd9, 6'd0, 6'd9}, 2'd1, 1};
    vecs[11] = '{3'b100, 3'b100, 6'b00_00_00, {6'd63, 6'd0, 6'd0}, 2'd2, 63};
    // Masked ch0 has top priority but must never win
    vecs[12] = '{3'b110, 3'b111, 6'b01_10_00, {6'd3, 6'd4, 6'd5}, 2'd2, 3};
    vecs[13] = '{3'b110, 3'b111, 6'b00_00_00, {6'd3, 6'd4, 6'd5}, 2'd1, 4};

    rst        = 1'b1;
    chnl_en    = 3'b000;
    slv_prios  = 6'b0;
    slv_reqs   = 3'b000;
    slv_lens   = '0;
    slv_vlds   = 3'b111;
    f2a_id_req = 1'b0;
    f2a_ack    = 1'b1;
    last_id    = 2'd0;
    for (int c = 0; c < 3; c++) pop_cnt[c] = 0;
    refresh_data();
    tick();
    tick();
    chk("rst state", 64'(dut.state), 64'(IDLE));
    chk("rst val", 64'(a2f_val), 64'd0);
    chk("rst id", 64'(a2f_id), 64'd0);
    chk("rst len", 64'(a2f_len), 64'd0);
    chk("rst data", 64'(a2f_data), 64'd0);
    chk("rst acks", 64'(a2s_acks), 64'd0);
    chk("rst last_grant", 64'(dut.last_grant), 64'd2);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      chnl_en   = vecs[i].en;
      slv_reqs  = vecs[i].reqs;
      slv_prios = vecs[i].prios;
      slv_lens  = vecs[i].lens;
      run_pkt(vecs[i].exp_id, vecs[i].exp_len, 1'b0, $sformatf("vec%0d", i));
    end

    // Stalls on ack and valid; enables/requests vanish mid-packet
    chnl_en   = 3'b001;
    slv_reqs  = 3'b001;
    slv_prios = 6'b00_00_00;
    slv_lens  = {6'd0, 6'd0, 6'd8};
    run_pkt(2'd0, 8, 1'b1, "stall");

    // Eligible vanishes during ARB: no grant, back to IDLE
    chnl_en    = 3'b111;
    slv_reqs   = 3'b010;
    f2a_id_req = 1'b1;
    tick();
    f2a_id_req = 1'b0;
    slv_reqs   = 3'b000;
    tick();
    chk("arbdrop state", 64'(dut.state), 64'(IDLE));
    chk("arbdrop val", 64'(a2f_val), 64'd0);
    chk("arbdrop id", 64'(a2f_id), 64'(last_id));
    tick();
    chk("arbdrop stay", 64'(dut.state), 64'(IDLE));

    // Reset during beat 3 of an 8-beat packet
    slv_reqs   = 3'b111;
    slv_lens   = {6'd8, 6'd8, 6'd8};
    f2a_id_req = 1'b1;
    tick();
    f2a_id_req = 1'b0;
    tick();
    tick();
    tick();
    chk("midrst beat3 val", 64'(a2f_val), 64'd1);
    rst = 1'b1;
    tick();
    chk("midrst acks", 64'(a2s_acks), 64'd0);
    chk("midrst val", 64'(a2f_val), 64'd0);
    chk("midrst state", 64'(dut.state), 64'(IDLE));
    chk("midrst last_grant", 64'(dut.last_grant), 64'd2);
    chk("midrst len", 64'(a2f_len), 64'd0);
    rst = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) pop_cnt[c] = 0;
    refresh_data();
    run_pkt(2'd0, 8, 1'b0, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mcdf_arbiter.md
Name: mcdf_arbiter

Overview:
- Sits between the three MCDF slave channel FIFOs and the formatter.
- When the formatter asks for a new packet (f2a_id_req), the arbiter selects one requesting, enabled channel by 2-bit priority, breaking ties round-robin.
- It then streams that channel's packet beats to the formatter and pops the channel with a2s_acks.
- It locks onto the chosen channel for exactly one packet of the programmed length.

Parameters:
- DW, 32, data width of each channel and of the formatter data path.
- LENW, 6, width of the per-channel packet length field (in beats).

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- chnl_en  in  3  per-channel enable; disabled channels are never granted.
- slv_prios  in  6  2-bit priority per channel, [2i+1:2i]; 0 = highest.
- slv_reqs  in  3  channel i holds at least one complete packet.
- slv_lens  in  3*LENW  packet length per channel in beats; 0 is treated as 1.
- slv_datas  in  3*DW  head-of-FIFO data per channel.
- slv_vlds  in  3  head-of-FIFO data valid per channel.
- a2s_acks  out  3  pop strobe to channel i for the current beat.
- f2a_id_req  in  1  formatter ready to start a new packet.
- f2a_ack  in  1  formatter accepts the current data beat.
- a2f_val  out  1  a2f_data is valid.
- a2f_id  out  2  channel id of the current packet.
- a2f_data  out  DW  current beat data.
- a2f_len  out  LENW  length of the current packet, held for the whole packet.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, a2f_val=0, a2f_id=0, a2f_len=0, a2f_data=0, beat_cnt=0, last_grant=2 (so ch0 wins the first tie).
- FSM states: IDLE, ARB, XFER.
- IDLE -> ARB when f2a_id_req=1 and eligible=(slv_reqs & chnl_en) is nonzero. Otherwise stay in IDLE.
- ARB (exactly 1 cycle):
  - Compute best = minimum slv_prios over eligible channels.
  - Among eligible channels with prio==best, pick the first one scanning from last_grant+1 mod 3 upward, wrapping.
  - Register the winner into a2f_id and last_grant.
  - Register a2f_len = (slv_lens[id]==0) ? 1 : slv_lens[id].
  - Clear beat_cnt, then go to XFER.
  - If eligible became 0 in ARB, return to IDLE with no grant.
- XFER:
  - a2f_val = slv_vlds[a2f_id].
  - a2f_data = slv_datas[a2f_id] (combinational mux, zero latency).
  - a2s_acks[a2f_id] = a2f_val & f2a_ack; all other acks are 0.
  - Each acked beat increments beat_cnt.
  - On the acked beat where beat_cnt==a2f_len-1, go to IDLE.
- Ack gating: a2s_acks and a2f_val are 0 in IDLE and ARB. At most one ack bit is ever high.
- First-packet latency: request seen in IDLE -> winner registered at end of ARB -> first beat can transfer in the 2nd cycle after f2a_id_req.
- Changes during a packet:
  - f2a_id_req in ARB or XFER is ignored.
  - slv_reqs or chnl_en changing during XFER does not abort the packet.
  - slv_prios changes take effect at the next ARB.
- Stalls: slv_vlds=0 or f2a_ack=0 stalls without counting the beat.
- Reset mid-packet: next edge forces IDLE. acks and val drop that cycle and the partial packet is abandoned.
- Length of 2^LENW-1 beats must count correctly; beat_cnt is LENW bits wide with no wrap inside a packet.

Decomposition:
- Package mcdf_arb_pkg holds:
  - typedef state_e {IDLE, ARB, XFER}
  - typedef chid_t logic[1:0]
  - localparam NCH=3
  - function next_rr(...)
- One natural sub-module: mcdf_rr_prio_sel. It is purely combinational: (eligible, prios, last_grant) -> winner id and valid.

Test Plan:
- Single channel: chnl_en=3'b001, slv_reqs=001, slv_lens[0]=4, f2a_ack=1 always, pulse f2a_id_req -> ARB for 1 cycle, then 4 beats with a2f_id=0 and a2s_acks=001; back in IDLE after the 4th beat.
- Priority: all channels requesting, prios ch0=2, ch1=0, ch2=1 -> grant order ch1, ch2, ch0 over three requests, each requested after the previous packet ends.
- Round-robin tie: all prios=1, all requesting, lens=2, six consecutive requests -> grant order 0,1,2,0,1,2.
- Stalls and zero length: toggle f2a_ack and slv_vlds mid-packet, len=8 -> exactly 8 acks with data in FIFO order. A separate packet with len=0 transfers exactly 1 beat.
- Masking and reset: chnl_en=3'b110 with ch0 at top priority -> ch0 never granted. Assert rst during beat 3 of 8 -> next cycle acks=0, a2f_val=0, state IDLE, last_grant=2.
